// File: rtl/branch_resolver.sv
// Branch resolver: in-order prediction queue compared against execute outcomes,
// producing registered flush/redirect and BHT update. Optional stats: `BR_STATS_EN.
module branch_resolver #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pred_valid,
    input  logic [PC_W-1:0] pred_pc,
    input  logic            pred_taken,
    input  logic [PC_W-1:0] pred_target,
    output logic            pred_ready,
    input  logic            res_valid,
    input  logic            res_taken,
    input  logic [PC_W-1:0] res_target,
    output logic            flush,
    output logic [PC_W-1:0] redirect_pc,
    output logic            upd_valid,
    output logic [PC_W-1:0] upd_pc,
    output logic            upd_taken,
    output logic [PC_W-1:0] upd_target,
    output logic            res_err
`ifdef BR_STATS_EN
    ,
    output logic [31:0]     stat_resolved,
    output logic [31:0]     stat_mispred
`endif
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PC_W-1:0]  PC_STEP  = PC_W'(4);

    logic [PC_W-1:0]  r_pcMem  [DEPTH];
    logic [PC_W-1:0]  r_tgtMem [DEPTH];
    logic             r_tknMem [DEPTH];
    logic [PTR_W-1:0] r_headPtr;
    logic [PTR_W-1:0] r_tailPtr;
    logic [PTR_W:0]   r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_resErr;
    logic [PC_W-1:0]  w_headPc;
    logic [PC_W-1:0]  w_headTgt;
    logic             w_headTkn;
    logic [PC_W-1:0]  w_pc4;
    logic [PC_W-1:0]  w_expPc;
    logic [PC_W-1:0]  w_actPc;
    logic             w_mis;

    // A flush cycle discards everything, so both push and pop are gated by it.
    assign pred_ready = (r_count != FULL_CNT);
    assign w_push     = pred_valid & pred_ready & ~flush;
    assign w_pop      = res_valid & (r_count != '0) & ~flush;
    assign w_resErr   = res_valid & (r_count == '0) & ~flush;

    assign w_headPc   = r_pcMem[r_headPtr];
    assign w_headTgt  = r_tgtMem[r_headPtr];
    assign w_headTkn  = r_tknMem[r_headPtr];
    assign w_pc4      = w_headPc + PC_STEP;
    assign w_expPc    = w_headTkn ? w_headTgt : w_pc4;
    assign w_actPc    = res_taken ? res_target : w_pc4;
    assign w_mis      = (w_expPc != w_actPc);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pcMem[r_tailPtr]  <= pred_pc;
            r_tgtMem[r_tailPtr] <= pred_target;
            r_tknMem[r_tailPtr] <= pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_headPtr <= '0;
            r_tailPtr <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_tailPtr <= r_tailPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_headPtr <= r_headPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Result registers hold their last value between pops; only the strobes fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
            upd_valid   <= 1'b0;
            upd_pc      <= '0;
            upd_taken   <= 1'b0;
            upd_target  <= '0;
            res_err     <= 1'b0;
        end else begin
            flush     <= w_pop & w_mis;
            upd_valid <= w_pop;
            if (w_pop) begin
                redirect_pc <= w_actPc;
                upd_pc      <= w_headPc;
                upd_taken   <= res_taken;
                upd_target  <= res_target;
            end
            if (w_resErr) begin
                res_err <= 1'b1;
            end
        end
    end

`ifdef BR_STATS_EN
    // Counters observe the registered strobes, so they lag the pop by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else begin
            if (upd_valid && (stat_resolved != 32'hFFFF_FFFF)) begin
                stat_resolved <= stat_resolved + 32'd1;
            end
            if (flush && (stat_mispred != 32'hFFFF_FFFF)) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Resolution end of the fetch-side branch prediction path.
- Records every prediction issued at fetch in an in-order queue, then compares the oldest one against the actual outcome from execute.
- Generates the registered mispredict/flush pulse and redirect PC consumed by fetch, plus the BHT update write.
- Sits between the execute stage's branch unit and the PC/BHT logic.

Parameters:
PC_W, 32, PC and target width
DEPTH, 4, prediction queue entries (power of 2, >= 2)
PTR_W, 2, log2(DEPTH)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
pred_valid  in  1  fetch pushes one prediction record this cycle
pred_pc  in  PC_W  PC of the predicted control-flow instruction
pred_taken  in  1  fetch predicted taken
pred_target  in  PC_W  predicted target (used only when pred_taken)
pred_ready  out  1  queue not full; combinational from count
res_valid  in  1  execute resolves the oldest outstanding control-flow instruction
res_taken  in  1  actual direction (1 for jal/jalr)
res_target  in  PC_W  actual target (used only when res_taken)
flush  out  1  one-cycle mispredict pulse to fetch/pipeline
redirect_pc  out  PC_W  correct next PC, valid while flush=1
upd_valid  out  1  one-cycle BHT write strobe
upd_pc  out  PC_W  BHT index PC
upd_taken  out  1  outcome to train
upd_target  out  PC_W  target to store
res_err  out  1  sticky: resolve with empty queue

Behaviour:
- Reset (rst=1 at an edge): queue empty, head=tail=0, count=0. flush, upd_valid and res_err are 0. redirect_pc, upd_pc and upd_target are 0. upd_taken is 0. Reset overrides every other input in the same cycle.
- Push:
  - Condition: pred_valid & pred_ready & !flush.
  - Write {pred_pc, pred_taken, pred_target} at tail; tail = tail+1 mod DEPTH.
  - pred_valid while full: record dropped, no state change.
- Pop:
  - Condition: res_valid & count!=0 & !flush.
  - Read the head entry; head = head+1 mod DEPTH.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Full with concurrent pop: push still refused, because pred_ready depends only on count.
- Arithmetic, all modulo 2^PC_W:
  - pc4 = head.pc + 4.
  - exp = head.taken ? head.target : pc4.
  - act = res_taken ? res_target : pc4.
  - mis = (exp != act).
- Latency: pop in cycle N; results appear in cycle N+1:
  - flush = mis; redirect_pc = act.
  - upd_valid = 1; upd_pc = head.pc; upd_taken = res_taken; upd_target = res_target.
- All outputs are registered. flush and upd_valid return to 0 the next cycle unless another pop occurred.
- Cycle with flush=1:
  - Queue cleared: head=tail=0, count=0. All younger entries are wrong-path.
  - pred_valid and res_valid in this cycle are ignored, with no push, pop or error.
- res_valid & count==0 & !flush: res_err set to 1 and held until reset; no other effect.
- Pointer wrap: at DEPTH-1 the pointer increments to 0. Full is count==DEPTH; empty is count==0.

Optional Feature:
BR_STATS_EN
- Defined:
  - Adds outputs stat_resolved[31:0] and stat_mispred[31:0]. Both reset to 0.
  - On each cycle with upd_valid=1, stat_resolved increments; stat_mispred increments when flush=1.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle 3 cycles -> flush=0, upd_valid=0, res_err=0, pred_ready=1.
- Correct prediction:
  - Stimulus: push pc=0x100, taken=1, target=0x200; next cycle res_valid, taken=1, target=0x200.
  - Required, one cycle later: upd_valid=1, upd_pc=0x100, flush=0.
- Wrong direction:
  - Stimulus: push pc=0x40, taken=1, target=0x80; resolve res_taken=0.
  - Required, next cycle: flush=1, redirect_pc=0x44; queue empty afterwards.
- Full queue:
  - Push 4 entries -> pred_ready=0; fifth push dropped.
  - Resolve all 4 correctly -> upd_pc values come out in push order.
  - Pointers wrap, proven by 4 more push/resolve pairs.
- Flush with concurrent events:
  - Stimulus: queue holds 2 entries; oldest mispredicts, and in the flush cycle pred_valid=1 and res_valid=1.
  - Required: count=0 after, no upd_valid in the following cycle, res_err=0.
- Resolve on empty queue -> res_err=1 and stays 1. With BR_STATS_EN, stat_resolved equals the number of upd_valid pulses.
